// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point adder/subtractor with parameterised exponent and fraction widths.
// One operation in flight; round-to-nearest-even, saturating overflow, flush-to-zero underflow.
`timescale 1ns/1ps
module fpu_addsub_param #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                   clock100KHz,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   op_A_in,
  input  logic [EXP_W+MAN_W:0]   op_B_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   data_out,
  output logic [3:0]             status_out
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int XW   = SW + 3;
  localparam int EW   = EXP_W + 2;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [W-1:0]          a_reg, b_reg, special_val_reg, data_reg;
  logic                  sub_reg, big_sign_reg, small_sign_reg, sign_reg;
  logic                  special_reg, zero_reg;
  logic signed [EW-1:0]  exp_reg;
  logic [XW-1:0]         big_reg, small_reg, norm_reg;
  logic [XW:0]           sum_reg;
  logic [3:0]            status_reg;

  always_ff @(posedge clock100KHz) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_ALIGN;
      S_ALIGN:  state_next = S_ADDSUB;
      S_ADDSUB: state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Alignment: larger exponent keeps its significand, the other shifts right into G/R/S.
  logic [EXP_W-1:0] a_exp, b_exp, hi_exp, exp_diff;
  logic             b_sign_eff, a_ge, hi_sign, lo_sign, a_zero, b_zero;
  logic [SW-1:0]    hi_sig, lo_sig;
  logic [2*SW+1:0]  lo_wide;
  logic [XW-1:0]    lo_ext;
  logic [W-1:0]     special_val;

  always_comb begin
    a_exp      = a_reg[W-2:MAN_W];
    b_exp      = b_reg[W-2:MAN_W];
    a_zero     = (a_exp == '0);
    b_zero     = (b_exp == '0);
    b_sign_eff = b_reg[W-1] ^ sub_reg;
    a_ge       = (a_exp >= b_exp);
    hi_sign    = a_ge ? a_reg[W-1] : b_sign_eff;
    lo_sign    = a_ge ? b_sign_eff : a_reg[W-1];
    hi_exp     = a_ge ? a_exp : b_exp;
    hi_sig     = a_ge ? {1'b1, a_reg[MAN_W-1:0]} : {1'b1, b_reg[MAN_W-1:0]};
    lo_sig     = a_ge ? {1'b1, b_reg[MAN_W-1:0]} : {1'b1, a_reg[MAN_W-1:0]};
    exp_diff   = a_ge ? (a_exp - b_exp) : (b_exp - a_exp);
    lo_wide    = {lo_sig, {(SW+2){1'b0}}} >> exp_diff;
    if (int'(exp_diff) >= SW + 2) lo_ext = {{(XW-1){1'b0}}, 1'b1};
    else                          lo_ext = {lo_wide[2*SW+1:SW], |lo_wide[SW-1:0]};
    if (a_zero && b_zero) special_val = {a_reg[W-1] & b_sign_eff, {(W-1){1'b0}}};
    else if (a_zero)      special_val = {b_sign_eff, b_reg[W-2:0]};
    else                  special_val = a_reg;
  end

  logic [XW:0] sum_next;
  logic        sign_next;

  always_comb begin
    if (big_sign_reg == small_sign_reg) begin
      sum_next  = {1'b0, big_reg} + {1'b0, small_reg};
      sign_next = big_sign_reg;
    end else if (big_reg >= small_reg) begin
      sum_next  = {1'b0, big_reg} - {1'b0, small_reg};
      sign_next = big_sign_reg;
    end else begin
      sum_next  = {1'b0, small_reg} - {1'b0, big_reg};
      sign_next = small_sign_reg;
    end
  end

  // Deep cancellation is clamped to -2 so the narrow exponent cannot wrap; it still underflows after a round carry.
  int                   lz;
  logic                 found;
  logic [XW-1:0]        norm_next;
  logic signed [EW-1:0] exp_norm;

  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found && sum_reg[i]) begin
        lz    = XW - 1 - i;
        found = 1'b1;
      end
    end
    norm_next = sum_reg[XW-1:0];
    exp_norm  = exp_reg;
    if (sum_reg[XW]) begin
      norm_next = {sum_reg[XW:2], sum_reg[1] | sum_reg[0]};
      exp_norm  = exp_reg + EW'(1);
    end else begin
      norm_next = sum_reg[XW-1:0] << lz;
      if (lz > int'(exp_reg) + 2) exp_norm = EW'(-2);
      else                        exp_norm = exp_reg - EW'(lz);
    end
  end

  logic [SW-1:0]        rnd_sig;
  logic [SW:0]          sig_rounded;
  logic                 round_up, inexact;
  logic [MAN_W-1:0]     frac_f;
  logic signed [EW-1:0] exp_f;
  logic [W-1:0]         result;
  logic [3:0]           status_next;

  always_comb begin
    rnd_sig     = norm_reg[XW-1:3];
    inexact     = |norm_reg[2:0];
    round_up    = norm_reg[2] & (norm_reg[1] | norm_reg[0] | rnd_sig[0]);
    sig_rounded = {1'b0, rnd_sig} + {{SW{1'b0}}, round_up};
    if (sig_rounded[SW]) begin
      frac_f = sig_rounded[MAN_W:1];
      exp_f  = exp_reg + EW'(1);
    end else begin
      frac_f = sig_rounded[MAN_W-1:0];
      exp_f  = exp_reg;
    end
    if (special_reg) begin
      result      = special_val_reg;
      status_next = 4'b0001;
    end else if (zero_reg) begin
      result      = '0;
      status_next = 4'b0001;
    end else if (int'(exp_f) > EMAX) begin
      result      = {sign_reg, {(W-1){1'b1}}};
      status_next = 4'b0100;
    end else if (int'(exp_f) < 1) begin
      result      = {sign_reg, {(W-1){1'b0}}};
      status_next = 4'b1000;
    end else begin
      result      = {sign_reg, exp_f[EXP_W-1:0], frac_f};
      status_next = inexact ? 4'b0010 : 4'b0001;
    end
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      a_reg           <= '0;
      b_reg           <= '0;
      sub_reg         <= 1'b0;
      big_reg         <= '0;
      small_reg       <= '0;
      big_sign_reg    <= 1'b0;
      small_sign_reg  <= 1'b0;
      exp_reg         <= '0;
      special_reg     <= 1'b0;
      special_val_reg <= '0;
      sum_reg         <= '0;
      sign_reg        <= 1'b0;
      zero_reg        <= 1'b0;
      norm_reg        <= '0;
      data_reg        <= '0;
      status_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          a_reg   <= op_A_in;
          b_reg   <= op_B_in;
          sub_reg <= op_sub;
        end
        S_ALIGN: begin
          big_reg         <= {hi_sig, 3'b000};
          small_reg       <= lo_ext;
          big_sign_reg    <= hi_sign;
          small_sign_reg  <= lo_sign;
          exp_reg         <= $signed({2'b00, hi_exp});
          special_reg     <= a_zero | b_zero;
          special_val_reg <= special_val;
        end
        S_ADDSUB: begin
          sum_reg  <= sum_next;
          sign_reg <= sign_next;
          zero_reg <= (sum_next == '0);
        end
        S_NORM: begin
          norm_reg <= norm_next;
          exp_reg  <= exp_norm;
        end
        S_ROUND: begin
          data_reg   <= result;
          status_reg <= status_next;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign data_out   = data_reg;
  assign status_out = status_reg;
endmodule

// File: tb/tb_fpu_addsub_param.sv
// Bench for fpu_addsub_param: directed vectors, reset/abort behaviour and random
// operations checked against an exact wide-integer reference model.
`timescale 1ns/1ps
module tb_fpu_addsub_param;
  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SW    = MAN_W + 1;
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam int MW    = 130;

  logic         clock100KHz = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] op_A_in = '0;
  logic [W-1:0] op_B_in = '0;
  logic         busy, done;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  int n_checks = 0;
  int n_errors = 0;

  fpu_addsub_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clock100KHz(clock100KHz),
    .reset(reset),
    .start(start),
    .op_sub(op_sub),
    .op_A_in(op_A_in),
    .op_B_in(op_B_in),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .status_out(status_out)
  );

  always #5 clock100KHz = ~clock100KHz;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Exact value = signed sum of significands scaled by 2^(exp-1), rounded once to nearest-even.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] res, output logic [3:0] st);
    logic sa, sb, neg, inexact, found;
    int ea, eb, p, e, sh;
    logic [MW-1:0] ma, mb, mag, q, rem, half, one;
    logic signed [MW-1:0] v;
    one = 1;
    sa  = a[W-1];
    sb  = b[W-1] ^ sub;
    ea  = int'(a[W-2:MAN_W]);
    eb  = int'(b[W-2:MAN_W]);
    res = '0;
    st  = 4'b0001;
    if (ea == 0 && eb == 0) begin
      res = {sa & sb, {(W-1){1'b0}}};
    end else if (ea == 0) begin
      res = {sb, b[W-2:0]};
    end else if (eb == 0) begin
      res = a;
    end else begin
      ma  = MW'({1'b1, a[MAN_W-1:0]}) << (ea - 1);
      mb  = MW'({1'b1, b[MAN_W-1:0]}) << (eb - 1);
      v   = (sa ? -$signed(ma) : $signed(ma)) + (sb ? -$signed(mb) : $signed(mb));
      neg = (v < 0);
      mag = neg ? -v : v;
      if (mag == '0) begin
        res = '0;
      end else begin
        p = 0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
          if (!found && mag[i]) begin
            p = i;
            found = 1'b1;
          end
        end
        e = p - MAN_W + 1;
        inexact = 1'b0;
        if (p > MAN_W) begin
          sh   = p - MAN_W;
          q    = mag >> sh;
          rem  = mag - (q << sh);
          half = one << (sh - 1);
          inexact = (rem != '0);
          if (rem > half || (rem == half && q[0])) q = q + 1;
          if (q == (one << SW)) begin
            q = q >> 1;
            e = e + 1;
          end
        end else begin
          q = mag << (MAN_W - p);
        end
        if (e > EMAX) begin
          res = {neg, {(W-1){1'b1}}};
          st  = 4'b0100;
        end else if (e < 1) begin
          res = {neg, {(W-1){1'b0}}};
          st  = 4'b1000;
        end else begin
          res = {neg, EXP_W'(e), q[MAN_W-1:0]};
          st  = inexact ? 4'b0010 : 4'b0001;
        end
      end
    end
  endfunction

  // One operation: start sampled at edge N, busy checked N+1..N+5, done only at N+5,
  // idle again at N+6. With hammer set, start and operands toggle throughout busy and DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit hammer, input logic [W-1:0] exp_res, input logic [3:0] exp_st,
                        input string tag);
    @(negedge clock100KHz);
    start = 1'b1;
    op_A_in = a;
    op_B_in = b;
    op_sub = sub;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock100KHz);
      if (hammer) begin
        start = 1'b1;
        op_A_in = $urandom;
        op_B_in = $urandom;
        op_sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
      check($sformatf("%s_done%0d", tag, k), 32'(done), (k == 5) ? 32'd1 : 32'd0);
    end
    check({tag, "_data"}, 32'(data_out), 32'(exp_res));
    check({tag, "_status"}, 32'(status_out), 32'(exp_st));
    check({tag, "_onehot"}, 32'($onehot(status_out)), 32'd1);
    @(negedge clock100KHz);
    start = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_held"}, 32'(data_out), 32'(exp_res));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic [3:0] es;
    logic rs;
    int eb;

    repeat (3) @(negedge clock100KHz);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_status", 32'(status_out), 32'd0);
    reset = 1'b0;
    @(negedge clock100KHz);
    check("post_rst_busy", 32'(busy), 32'd0);

    run_op(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, 4'b0001, "one_plus_one");
    run_op(32'h3E000000, 32'h40000000, 1'b0, 1'b1, 32'h41000000, 4'b0001, "one_plus_two");
    run_op(32'h3E000000, 32'h3E000000, 1'b1, 1'b0, 32'h00000000, 4'b0001, "cancel");
    run_op(32'h3E000000, 32'h0A000000, 1'b0, 1'b0, 32'h3E000000, 4'b0010, "tie_even");
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0100, "overflow");
    run_op(32'h02000000, 32'h02000001, 1'b1, 1'b0, 32'h80000000, 4'b1000, "underflow");
    run_op(32'h00000000, 32'h3E000000, 1'b1, 1'b0, 32'hBE000000, 4'b0001, "zero_a");
    run_op(32'h80000000, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 4'b0001, "zero_both");

    for (int t = 0; t < 300; t++) begin
      ra = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: begin
          eb = int'(ra[W-2:MAN_W]) + int'($urandom_range(0, 6)) - 3;
          if (eb < 1) eb = 1;
          if (eb > EMAX) eb = EMAX;
          rb = {1'($urandom), EXP_W'(eb), MAN_W'($urandom)};
        end
        2: rb = {ra[W-1] ^ ~rs, ra[W-2:0] ^ (W-1)'($urandom_range(0, 15))};
        3: begin
          ra[W-2:MAN_W] = {EXP_W{1'b1}};
          rb = {ra[W-1] ^ rs, {EXP_W{1'b1}}, MAN_W'($urandom)};
        end
        default: begin
          rb = $urandom;
          if ($urandom_range(0, 1) == 1) ra[W-2:MAN_W] = '0;
          else rb[W-2:MAN_W] = '0;
        end
      endcase
      model(ra, rb, rs, er, es);
      run_op(ra, rb, rs, 1'($urandom), er, es, $sformatf("rand%0d", t));
    end

    run_op(32'h3E000000, 32'h40000000, 1'b0, 1'b0, 32'h41000000, 4'b0001, "pre_abort");
    @(negedge clock100KHz);
    start = 1'b1;
    op_A_in = 32'h3E000000;
    op_B_in = 32'h40000000;
    op_sub = 1'b0;
    @(negedge clock100KHz);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock100KHz);
    reset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_busy%0d", k), 32'(busy), 32'd0);
      check($sformatf("abort_done%0d", k), 32'(done), 32'd0);
      check($sformatf("abort_data%0d", k), 32'(data_out), 32'd0);
      check($sformatf("abort_status%0d", k), 32'(status_out), 32'd0);
      @(negedge clock100KHz);
    end
    run_op(32'h3E000000, 32'h3E000000, 1'b0, 1'b0, 32'h40000000, 4'b0001, "recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fpu_addsub_param.md
FPU_ADDSUB_PARAM -- requirements
Module: fpu_addsub_param

Interface
REQ-001 Parameter EXP_W, default 6: exponent field width, legal range 3..11.
REQ-002 Parameter MAN_W, default 25: stored fraction width, legal range 4..52; W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1 (31 at defaults).
REQ-003 clock100KHz  in  1  single clock; all state SHALL change only on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op_sub  in  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 op_A_in  in  W  operand A {sign, exp[EXP_W], frac[MAN_W]}; sampled with start.
REQ-008 op_B_in  in  W  operand B, same format; sampled with start.
REQ-009 busy  out  1  high while an operation is in flight.
REQ-010 done  out  1  one-cycle pulse when data_out/status_out update.
REQ-011 data_out  out  W  result, held between done pulses.
REQ-012 status_out  out  4  one-hot: [0] EXACT, [1] INEXACT, [2] OVERFLOW, [3] UNDERFLOW.

Function
REQ-013 Number format: exp field 0 = zero (fraction ignored, no denormals); otherwise value = (-1)^s * 1.frac * 2^(exp-BIAS); all-ones exponent is an ordinary finite value (no Inf/NaN).
REQ-014 FSM states: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE -> IDLE; each non-IDLE state lasts exactly one cycle.
REQ-015 IDLE with start=1 at edge N: operands and op_sub registered, FSM to ALIGN; busy high in cycles N+1..N+5; done high only in cycle N+5.
REQ-016 start while busy SHALL be ignored (no queueing); start in the DONE cycle is also ignored; next accept no earlier than N+6.
REQ-017 op_sub=1 inverts B's sign before alignment.
REQ-018 ALIGN: larger-exponent operand kept; smaller significand right-shifted by the exponent difference into MAN_W+1 bits plus guard, round, sticky (sticky = OR of all bits shifted beyond round); difference >= MAN_W+3 leaves only sticky.
REQ-019 ADDSUB: equal effective signs add magnitudes, else subtract smaller from larger magnitude; result sign = sign of larger magnitude; exact cancellation gives +0.
REQ-020 NORM: single-cycle leading-one detect; carry-out -> shift right 1 (shifted-out bit joins sticky), exponent+1; else shift left to leading one, exponent decremented by shift count.
REQ-021 ROUND: round-to-nearest-even on guard/round/sticky; rounding carry to 2.0 renormalises and increments exponent.
REQ-022 Either operand zero: result equals the other operand (with effective sign), EXACT; both zero: sign = AND of effective signs.
REQ-023 Overflow (final exponent > 2^EXP_W-1): data_out = {sign, all-ones exp, all-ones frac}, status OVERFLOW.
REQ-024 Underflow (nonzero result, final exponent < 1): data_out = {sign, 0, 0}, status UNDERFLOW.
REQ-025 Otherwise status INEXACT if any of guard/round/sticky set before rounding, else EXACT; exactly one status bit set after any done.
REQ-026 Internal exponent arithmetic SHALL use EXP_W+2 signed bits so over/underflow never wraps.

Reset
REQ-027 reset=1 at an edge: FSM to IDLE, busy=0, done=0, data_out=0, status_out=4'b0000, all internal registers cleared; takes priority over start.
REQ-028 reset mid-operation aborts it; no done pulse for the aborted operation.

Verification (defaults EXP_W=6, MAN_W=25)
REQ-029 A=0x3E000000 (1.0), B=0x3E000000, op_sub=0 -> done at N+5, data_out=0x40000000, status=0001.
REQ-030 A=0x3E000000, B=0x40000000 (2.0), op_sub=0 -> 0x41000000 (3.0), 0001; same with op_sub=1 and A=B -> 0x00000000, 0001.
REQ-031 A=0x3E000000, B=0x0A000000 (2^-26, tie) -> 0x3E000000 (round to even), 0010.
REQ-032 A=B=0x7FFFFFFF, op_sub=0 -> 0x7FFFFFFF, 0100.
REQ-033 A=0x02000000, B=0x02000001, op_sub=1 -> 0x80000000, 1000.
REQ-034 start at N, reset at N+2 -> busy=0 and done=0 from N+3 on, data_out=0, status=0000; start repeated at N+1, N+3 during busy ignored.
